ddr3_cmd_responder: RTL and testbench

- Device-side responder for the DDR3 command/data interface driven by the team's controller state machine. It is the other end of that interface.
- Decodes CS/RAS/CAS/WE/BA/Addr each cycle, tracks the open row per bank and stores write bursts into a small behavioural array. It returns read bursts on the shared DQ bus after CL cycles.
- Used as the controller's bench-side memory and as a protocol checker.
- Data rate is simplified: one 16-bit beat per CLK rising edge.

---
 rtl/ddr3_cmd_pkg.sv | 28 ++
 rtl/ddr3_bank_tracker.sv | 30 +++
 rtl/ddr3_cmd_responder.sv | 126 ++++++++++++
 tb/tb_ddr3_cmd_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ddr3_cmd_pkg.sv
// ddr3_cmd_pkg: command encodings, decoded-command and burst-state types for the DDR3 responder
package ddr3_cmd_pkg;
  localparam logic [3:0] CMD_DES  = 4'b1111;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;

  typedef enum logic [3:0] {D_DES, D_NOP, D_ACT, D_PRE, D_RD, D_WR, D_REF, D_MRS, D_ZQCL} dcmd_e;
  typedef enum logic [1:0] {S_IDLE, S_LAT_WAIT, S_BURST} bst_e;

  // CS high deselects regardless of the other pins
  function automatic dcmd_e decode(input logic [3:0] c);
    return (c[3] == CMD_DES[3]) ? D_DES :
           (c == CMD_NOP)  ? D_NOP  :
           (c == CMD_ACT)  ? D_ACT  :
           (c == CMD_PRE)  ? D_PRE  :
           (c == CMD_RD)   ? D_RD   :
           (c == CMD_WR)   ? D_WR   :
           (c == CMD_REF)  ? D_REF  :
           (c == CMD_MRS)  ? D_MRS  :
           (c == CMD_ZQCL) ? D_ZQCL : D_NOP;
  endfunction
endpackage

// File: rtl/ddr3_bank_tracker.sv
// ddr3_bank_tracker: per-bank open flag and latched row, updated by ACT/PRE/PREA
module ddr3_bank_tracker #(
  parameter int ROW_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_act,
  input  logic             i_pre,
  input  logic             i_prea,
  input  logic [2:0]       i_ba,
  input  logic [ROW_W-1:0] i_row,
  output logic             o_open,
  output logic             o_any_open,
  output logic [ROW_W-1:0] o_row
);
  logic [7:0]       r_open;
  logic [ROW_W-1:0] r_row [8];

  always_ff @(posedge i_clk)
    if (!i_rst_n || i_prea) r_open <= '0;
    else if (i_act) r_open[i_ba] <= 1'b1;
    else if (i_pre) r_open[i_ba] <= 1'b0;

  always_ff @(posedge i_clk)
    if (i_act) r_row[i_ba] <= i_row;

  assign o_open     = r_open[i_ba];
  assign o_any_open = |r_open;
  assign o_row      = r_row[i_ba];
endmodule

// File: rtl/ddr3_cmd_responder.sv
// ddr3_cmd_responder: device-side DDR3 command decoder, bank checker and behavioural burst memory
// One 16-bit beat per rising edge; one read or write burst outstanding at a time.
module ddr3_cmd_responder
  import ddr3_cmd_pkg::*;
#(
  parameter int CL       = 5,
  parameter int CWL      = 5,
  parameter int BL       = 8,
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 5
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        CKE,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [2:0]  BA,
  input  logic [14:0] Addr,
  input  logic        LDM,
  input  logic        UDM,
  inout  wire  [15:0] DQ,
  output logic        LDQS,
  output logic        UDQS,
  output logic [14:0] Mode0,
  output logic [15:0] Ref_count,
  output logic        Cmd_err,
  output logic        Busy
);
  localparam int LB = $clog2(BL);
  localparam int AW = 3 + ROW_BITS + COL_BITS;
  localparam logic [COL_BITS-1:0] W_MASK = COL_BITS'(BL - 1);
  localparam logic [7:0] RD_WAIT = 8'(CL - 2);
  localparam logic [7:0] WR_WAIT = 8'(CWL - 2);

  dcmd_e               w_cmd;
  bst_e                r_state, w_next;
  logic                w_open, w_any_open, w_rw, w_err, w_start, w_act, w_pre, w_prea, w_drive;
  logic [ROW_BITS-1:0] w_row;
  logic [AW-1:0]       w_addr;
  logic                r_rd;
  logic [2:0]          r_bank;
  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;
  logic [LB-1:0]       r_beat;
  logic [7:0]          r_lat;
  logic [15:0]         r_mem [2**AW];

  // auto-precharge closes the bank as the burst is accepted; the burst keeps r_row
  always_comb begin
    w_cmd   = CKE ? decode({CS, RAS, CAS, WE}) : D_NOP;
    w_rw    = (w_cmd == D_RD) || (w_cmd == D_WR);
    w_err   = ((w_cmd == D_ACT) && w_open) || (w_rw && (!w_open || Busy)) ||
              ((w_cmd == D_REF) && w_any_open);
    w_start = w_rw && !w_err;
    w_act   = (w_cmd == D_ACT) && !w_err;
    w_pre   = ((w_cmd == D_PRE) && !Addr[10]) || (w_start && Addr[10]);
    w_prea  = (w_cmd == D_PRE) && Addr[10];
    w_addr  = {r_bank, r_row, r_col};
  end

  ddr3_bank_tracker #(.ROW_W(ROW_BITS)) u_banks (
    .i_clk      (CLK),
    .i_rst_n    (RESET_n),
    .i_act      (w_act),
    .i_pre      (w_pre),
    .i_prea     (w_prea),
    .i_ba       (BA),
    .i_row      (Addr[ROW_BITS-1:0]),
    .o_open     (w_open),
    .o_any_open (w_any_open),
    .o_row      (w_row)
  );

  always_ff @(posedge CLK)
    r_state <= !RESET_n ? S_IDLE : w_next;

  always_comb begin
    w_next = (r_state == S_IDLE)     ? (!w_start ? S_IDLE :
                                        (((w_cmd == D_RD) ? CL : CWL) == 1) ? S_BURST : S_LAT_WAIT) :
             (r_state == S_LAT_WAIT) ? ((r_lat == 8'd0) ? S_BURST : S_LAT_WAIT) :
                                       ((r_beat == LB'(BL - 1)) ? S_IDLE : S_BURST);
  end

  always_comb begin
    Busy    = r_state != S_IDLE;
    w_drive = (r_state == S_BURST) && r_rd;
    LDQS    = w_drive;
    UDQS    = w_drive;
  end

  // column walks sequentially, wrapping inside the BL-aligned block
  always_ff @(posedge CLK)
    if (w_start) begin
      r_rd   <= w_cmd == D_RD;
      r_bank <= BA;
      r_row  <= w_row;
      r_col  <= Addr[COL_BITS-1:0];
      r_beat <= '0;
      r_lat  <= (w_cmd == D_RD) ? RD_WAIT : WR_WAIT;
    end else if (r_state == S_LAT_WAIT) r_lat <= r_lat - 8'd1;
    else if (r_state == S_BURST) begin
      r_beat <= r_beat + 1'b1;
      r_col  <= (r_col & ~W_MASK) | ((r_col + 1'b1) & W_MASK);
    end

  always_ff @(posedge CLK)
    if (RESET_n && (r_state == S_BURST) && !r_rd) begin
      if (!LDM) r_mem[w_addr][7:0]  <= DQ[7:0];
      if (!UDM) r_mem[w_addr][15:8] <= DQ[15:8];
    end

  assign DQ = w_drive ? r_mem[w_addr] : 'z;

  always_ff @(posedge CLK)
    if (!RESET_n) begin
      Cmd_err   <= 1'b0;
      Ref_count <= '0;
      Mode0     <= '0;
    end else begin
      Cmd_err <= w_err;
      if ((w_cmd == D_REF) && !w_err && (Ref_count != 16'hFFFF)) Ref_count <= Ref_count + 16'd1;
      if ((w_cmd == D_MRS) && (BA == 3'd0)) Mode0 <= Addr;
    end
endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// tb_ddr3_cmd_responder: scoreboard bench; read beats are predicted from a bench memory model
module tb_ddr3_cmd_responder;
  localparam int CL = 5, CWL = 5, BL = 8;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100,
                         C_REF = 4'b0001, C_MRS = 4'b0000;

  logic        CLK = 1'b0, RESET_n, CKE, CS, RAS, CAS, WE, LDM, UDM;
  logic [2:0]  BA;
  logic [14:0] Addr;
  wire  [15:0] DQ;
  logic [15:0] dq_drv;
  logic        dq_oe;
  logic        LDQS, UDQS, Cmd_err, Busy;
  logic [14:0] Mode0;
  logic [15:0] Ref_count;

  assign DQ = dq_oe ? dq_drv : 'z;

  ddr3_cmd_responder #(.CL(CL), .CWL(CWL), .BL(BL), .ROW_BITS(2), .COL_BITS(5)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .CKE(CKE), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .BA(BA), .Addr(Addr), .LDM(LDM), .UDM(UDM), .DQ(DQ), .LDQS(LDQS), .UDQS(UDQS),
    .Mode0(Mode0), .Ref_count(Ref_count), .Cmd_err(Cmd_err), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct { int t; logic [15:0] d; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [15:0] mm [int];
  int          cyc = 0, n_cmd = 0, n_chk = 0, n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int key(input logic [2:0] ba, input logic [1:0] row, input logic [4:0] col);
    return int'({ba, row, col});
  endfunction

  function automatic logic [4:0] wcol(input logic [4:0] col, input int k);
    return {col[4:3], 3'(col[2:0] + 3'(k))};
  endfunction

  // beat k of a read is on DQ at the negedge n_cmd + CL + k
  always @(negedge CLK)
    if (LDQS) begin
      if (sb.size() == 0) check("rd_spurious", 32'(LDQS), 32'd0);
      else begin
        e = sb.pop_front();
        check("rd_time", cyc, e.t);
        check("rd_data", 32'(DQ), 32'(e.d));
        check("udqs", 32'(UDQS), 32'd1);
      end
    end

  task automatic cmd(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a);
    @(negedge CLK);
    {CS, RAS, CAS, WE} = c; BA = ba; Addr = a; n_cmd = cyc;
    @(negedge CLK);
    {CS, RAS, CAS, WE} = C_NOP;
  endtask

  task automatic wr(input logic [2:0] ba, input logic [1:0] row, input logic [4:0] col,
                    input logic [15:0] base, input logic ldm, input logic udm);
    logic [15:0] v;
    int          i;
    cmd(C_WR, ba, {10'd0, col});
    check("wr_err", 32'(Cmd_err), 32'd0);
    check("wr_busy", 32'(Busy), 32'd1);
    repeat (CWL - 1) @(negedge CLK);
    for (int k = 0; k < BL; k++) begin
      dq_drv = base + 16'(k); dq_oe = 1'b1; LDM = ldm; UDM = udm;
      i = key(ba, row, wcol(col, k));
      v = mm.exists(i) ? mm[i] : 16'h0;
      if (!ldm) v[7:0] = dq_drv[7:0];
      if (!udm) v[15:8] = dq_drv[15:8];
      mm[i] = v;
      @(negedge CLK);
    end
    dq_oe = 1'b0; LDM = 1'b0; UDM = 1'b0;
    check("wr_done_busy", 32'(Busy), 32'd0);
  endtask

  task automatic rd(input logic [2:0] ba, input logic [1:0] row, input logic [4:0] col,
                    input logic ap, input logic ok, input int nb);
    cmd(C_RD, ba, {4'd0, ap, 5'd0, col});
    check("rd_err", 32'(Cmd_err), 32'(!ok));
    if (ok)
      for (int k = 0; k < nb; k++) sb.push_back('{n_cmd + CL + k, mm[key(ba, row, wcol(col, k))]});
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || Busy); i++) @(negedge CLK);
    check("drain_sb", sb.size(), 0);
    check("drain_busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET_n = 1'b0; CKE = 1'b1; {CS, RAS, CAS, WE} = C_NOP; BA = '0; Addr = '0;
    LDM = 1'b0; UDM = 1'b0; dq_oe = 1'b0; dq_drv = '0;
    repeat (3) @(negedge CLK);
    RESET_n = 1'b1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ldqs", 32'(LDQS), 32'd0);
    check("rst_err", 32'(Cmd_err), 32'd0);
    check("rst_ref", 32'(Ref_count), 32'd0);
    check("rst_mode0", 32'(Mode0), 32'd0);
    cmd(C_REF, 3'd0, 15'd0);
    check("ref_err", 32'(Cmd_err), 32'd0);
    check("ref_cnt", 32'(Ref_count), 32'd1);
    cmd(C_MRS, 3'd0, 15'h1234);
    check("mode0", 32'(Mode0), 32'h1234);
    cmd(C_MRS, 3'd1, 15'h0777);
    check("mode0_ba1", 32'(Mode0), 32'h1234);
    // round trip with wrapped column order
    cmd(C_ACT, 3'd3, 15'd5);
    check("act_err", 32'(Cmd_err), 32'd0);
    wr(3'd3, 2'd1, 5'd7, 16'hF015, 1'b0, 1'b0);
    rd(3'd3, 2'd1, 5'd7, 1'b0, 1'b1, BL);
    drain();
    // byte mask: upper byte kept from first write
    cmd(C_ACT, 3'd2, 15'd3);
    wr(3'd2, 2'd3, 5'd0, 16'hA5A5, 1'b0, 1'b0);
    wr(3'd2, 2'd3, 5'd0, 16'h1234, 1'b0, 1'b1);
    rd(3'd2, 2'd3, 5'd0, 1'b0, 1'b1, BL);
    drain();
    // protocol errors
    rd(3'd5, 2'd0, 5'd0, 1'b0, 1'b0, BL);
    @(negedge CLK);
    check("err_pulse", 32'(Cmd_err), 32'd0);
    check("err_busy", 32'(Busy), 32'd0);
    cmd(C_ACT, 3'd3, 15'd1);
    check("act_open_err", 32'(Cmd_err), 32'd1);
    cmd(C_REF, 3'd0, 15'd0);
    check("ref_open_err", 32'(Cmd_err), 32'd1);
    check("ref_cnt_hold", 32'(Ref_count), 32'd1);
    // auto-precharge read (row 5 still latched) then collision two cycles later
    rd(3'd3, 2'd1, 5'd2, 1'b1, 1'b1, BL);
    rd(3'd2, 2'd3, 5'd0, 1'b0, 1'b0, BL);
    drain();
    rd(3'd3, 2'd1, 5'd0, 1'b0, 1'b0, BL);
    // CKE low mid-burst: burst completes, ACT ignored without error
    rd(3'd2, 2'd3, 5'd4, 1'b0, 1'b1, BL);
    CKE = 1'b0;
    cmd(C_ACT, 3'd5, 15'd0);
    check("cke_err", 32'(Cmd_err), 32'd0);
    CKE = 1'b1;
    drain();
    cmd(C_ACT, 3'd5, 15'd0);
    check("cke_act_ignored", 32'(Cmd_err), 32'd0);
    // reset during beat 3 of a read
    cmd(C_ACT, 3'd3, 15'd5);
    rd(3'd3, 2'd1, 5'd7, 1'b0, 1'b1, 4);
    repeat (CL + 2) @(negedge CLK);
    RESET_n = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b1;
    check("mid_rst_ldqs", 32'(LDQS), 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_sb", sb.size(), 0);
    check("mid_rst_ref", 32'(Ref_count), 32'd0);
    rd(3'd2, 2'd3, 5'd0, 1'b0, 1'b0, BL);
    cmd(C_ACT, 3'd3, 15'd5);
    check("post_rst_act", 32'(Cmd_err), 32'd0);
    rd(3'd3, 2'd1, 5'd7, 1'b0, 1'b1, BL);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
